div_issue_queue: RTL and testbench
==================================

DIV_ISSUE_QUEUE -- requirements
Module: div_issue_queue

Interface
REQ-001 The block SHALL have one clock and reset: the reset is asynchronous and active-high, and the clock and reset ports are named clk and rst as elsewhere in the codebase.
REQ-002 DEPTH, default 4, meaning the number of queued divide uops (power of two, at least 2).
REQ-003 clk, input, 1 bit, rising-edge clock.
REQ-004 rst, input, 1 bit, asynchronous active-high reset.
REQ-005 IN_branch, input, 52 bits, branch/flush bus: bit 51 is the flush valid, bits 18:13 are the flush sequence number.
REQ-006 IN_uop, input, 171 bits, the divide uop: bit 0 is valid, bits 25:20 are the sequence number (sqN), bits 42:37 are the opcode, and the remaining bits pass through unchanged.
REQ-007 IN_divBusy, input, 1 bit, the busy output of the downstream divider.
REQ-008 OUT_full, output, 1 bit, queue holds DEPTH entries.
REQ-009 OUT_en, output, 1 bit, the divider enable; it is high exactly when OUT_uop bit 0 is high.
REQ-010 OUT_uop, output, 171 bits, registered uop presented to the divider for exactly one cycle.

Function
REQ-011 The queue SHALL be an in-order FIFO (age order) of DEPTH entries using a read pointer, a write pointer, and a count of width log2(DEPTH)+1; pointers wrap modulo DEPTH.
REQ-012 An uop is kept by a flush iff signed 6-bit (uop sqN minus flush sqN) is less than or equal to 0; otherwise it is killed.
REQ-013 Enqueue SHALL occur when IN_uop bit 0 is high, OUT_full is low, and the uop is not killed by a same-cycle flush.
REQ-014 An enqueue attempted while OUT_full is high SHALL be dropped and SHALL fire a simulation assertion.
REQ-015 Issue SHALL occur when count is not 0, IN_divBusy is low, issuedLast is low, and no flush is valid this cycle.
- On issue, the head entry is registered into OUT_uop with bit 0 set to 1, the read pointer advances, and issuedLast is set to 1.
REQ-016 When issue does not occur, OUT_uop bit 0 SHALL be 0 in the next cycle, and issuedLast SHALL be 0.
- This enforces a one-cycle gap between issues, covering the cycle before the divider raises busy.
REQ-017 Enqueue and issue SHALL be allowed in the same cycle; count is then unchanged.
- Issue from empty plus enqueue in the same cycle is not allowed: there is no bypass, and the minimum queue latency is 1 cycle.
REQ-018 On a valid flush, the queue SHALL truncate from the tail so that count equals the number of kept entries.
- Because entries are in age order, killed entries are contiguous at the tail.
- The write pointer becomes read pointer plus the new count, and no issue occurs that cycle.
REQ-019 If the registered OUT_uop is killed by a flush, its bit 0 SHALL be cleared in the next cycle.
REQ-020 OUT_full SHALL be combinational from count, and SHALL equal 1 exactly when count equals DEPTH.

Reset
REQ-021 While rst is high, count, both pointers, issuedLast, and OUT_uop bit 0 SHALL be 0, and OUT_full and OUT_en SHALL be 0.
- The remaining bits of OUT_uop and the entry payloads are don't-care.
REQ-022 Reset asserted mid-operation SHALL discard all entries and any in-flight issue within the same cycle; no uop issues before the first clock edge after rst falls.

Structure
REQ-023 The shared package SHALL hold the uop field offsets (valid, sqN, opcode), the divide opcode constants (0 signed quotient, 1 unsigned quotient, 2 signed remainder, 3 unsigned remainder), and a sequence-number compare function used here and by the divider.
REQ-024 The block SHALL be a single module with no sub-modules; the entry storage is a flat register array.

Verification
REQ-025 Scenario: reset, then enqueue uops with sqN 1, 2, 3 on back-to-back cycles while IN_divBusy is 0.
- Required: OUT_en pulses for sqN 1, 2, 3 in order, exactly two cycles apart, and the first issue is one cycle after the first enqueue.
REQ-026 Scenario: IN_divBusy is held at 1 and 5 uops are enqueued.
- Required: after 4 uops OUT_full is 1, the 5th uop is dropped and the assertion fires, and no OUT_en occurs.
REQ-027 Scenario: the queue holds sqN 4, 5, 6, 7 and a flush with sqN 5 arrives.
- Required: count becomes 2, and later issues are sqN 4 then sqN 5 only.
REQ-028 Scenario: a flush with sqN 10 arrives in the same cycle as an enqueue of sqN 11, and another flush with sqN 10 arrives with an enqueue of sqN 10.
- Required: sqN 11 is not enqueued, and sqN 10 is enqueued.
REQ-029 Scenario: sqN wrap-around, with the queue holding sqN 62, 63, 0, 1 and a flush with sqN 63.
- Required: sqN 62 and 63 are kept, and sqN 0 and 1 are killed.
REQ-030 Scenario: rst is asserted asynchronously between edges while the queue is full with an issue pending.
- Required: OUT_en and OUT_full are 0 immediately, and after release the queue is empty.

Source files
------------

// File: rtl/div_issue_queue_pkg.sv
// Shared definitions for the divide issue path.
// Holds the uop and branch-bus field offsets, the divide opcode encodings
// and the sequence-number age compare used by the issue queue and the divider.
package div_issue_queue_pkg;

  localparam int UOP_W = 171;
  localparam int BR_W  = 52;
  localparam int SQN_W = 6;

  // uop field offsets
  localparam int UOP_VALID_BIT = 0;
  localparam int UOP_SQN_LO    = 20;
  localparam int UOP_SQN_HI    = 25;
  localparam int UOP_OPC_LO    = 37;
  localparam int UOP_OPC_HI    = 42;

  // branch/flush bus field offsets
  localparam int BR_FLUSH_VALID_BIT = 51;
  localparam int BR_FLUSH_SQN_LO    = 13;
  localparam int BR_FLUSH_SQN_HI    = 18;

  typedef enum logic [5:0] {
    DIV_S = 6'd0,  // signed quotient
    DIV_U = 6'd1,  // unsigned quotient
    REM_S = 6'd2,  // signed remainder
    REM_U = 6'd3   // unsigned remainder
  } div_op_e;

  // An uop survives a flush when it is not younger than the flushing uop:
  // the wrapped difference (sqn - flush_sqn), read as signed, is <= 0.
  function automatic logic sqn_kept(input logic [SQN_W-1:0] sqn,
                                    input logic [SQN_W-1:0] flush_sqn);
    logic [SQN_W-1:0] diff;
    diff = sqn - flush_sqn;
    return diff[SQN_W-1] || (diff == {SQN_W{1'b0}});
  endfunction

endpackage

// File: rtl/div_issue_queue_chk.sv
// Simulation checker for div_issue_queue.
// Flags an enqueue attempted while the queue is full (the uop is dropped).
// Ports: clk/rst as the queue; uop_valid/uop_sqn and flush_valid/flush_sqn
// are the incoming uop and flush fields; full is the queue's OUT_full;
// fire_count counts how many times the overflow assertion has fired.
module div_issue_queue_chk
  import div_issue_queue_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             uop_valid,
  input  logic [SQN_W-1:0] uop_sqn,
  input  logic             flush_valid,
  input  logic [SQN_W-1:0] flush_sqn,
  input  logic             full,
  output logic [7:0]       fire_count
);

  logic attempt_s;

  // A same-cycle flush that kills the uop means it was never an enqueue attempt.
  assign attempt_s = uop_valid && full && !(flush_valid && !sqn_kept(uop_sqn, flush_sqn));

  // Overflow assertion; each firing is counted so it can be observed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fire_count <= 8'd0;
    end else begin
      overflow_drop: assert (!attempt_s) else fire_count <= fire_count + 8'd1;
    end
  end

endmodule

// File: rtl/div_issue_queue.sv
// In-order issue queue in front of the divider.
// Holds DEPTH divide uops in age order, truncates younger entries on a flush,
// and presents one uop at a time to the divider for a single cycle, leaving at
// least one idle cycle between issues so the divider can raise busy.
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   IN_branch    flush bus (bit 51 valid, bits 18:13 flush sqN)
//   IN_uop       incoming uop (bit 0 valid, 25:20 sqN, 42:37 opcode)
//   IN_divBusy   divider busy
//   OUT_full     queue holds DEPTH entries
//   OUT_en       divider enable, mirrors OUT_uop bit 0
//   OUT_uop      registered uop for the divider
module div_issue_queue
  import div_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BR_W-1:0]  IN_branch,
  input  logic [UOP_W-1:0] IN_uop,
  input  logic             IN_divBusy,
  output logic             OUT_full,
  output logic             OUT_en,
  output logic [UOP_W-1:0] OUT_uop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [UOP_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;
  logic             issued_last_r;
  logic             out_valid_r;
  logic [UOP_W-1:1] out_payload_r;

  logic             flush_s;
  logic [SQN_W-1:0] flush_sqn_s;
  logic             in_killed_s;
  logic             enq_s;
  logic             issue_s;
  logic [CW-1:0]    kept_cnt_s;
  logic [CW-1:0]    next_count_s;
  logic [AW-1:0]    enq_idx_s;
  logic [AW-1:0]    next_rd_s;
  logic [AW-1:0]    next_wr_s;
  logic             unused_s;

  assign OUT_full = (count_r == CW'(DEPTH));
  assign OUT_uop  = {out_payload_r, out_valid_r};
  assign OUT_en   = out_valid_r;

  // Fields not consumed by the queue itself.
  assign unused_s = ^{IN_branch[BR_W-2:BR_FLUSH_SQN_HI+1], IN_branch[BR_FLUSH_SQN_LO-1:0],
                      mem_r[rd_ptr_r][UOP_VALID_BIT]};

  // Enqueue/issue decisions and kept-entry count under a flush.
  always_comb begin
    flush_sqn_s = IN_branch[BR_FLUSH_SQN_HI:BR_FLUSH_SQN_LO];
    flush_s     = IN_branch[BR_FLUSH_VALID_BIT];
    in_killed_s = flush_s && !sqn_kept(IN_uop[UOP_SQN_HI:UOP_SQN_LO], flush_sqn_s);
    enq_s       = IN_uop[UOP_VALID_BIT] && !OUT_full && !in_killed_s;
    issue_s     = (count_r != {CW{1'b0}}) && !IN_divBusy && !issued_last_r && !flush_s;

    // Entries are in age order, so killed ones form a contiguous tail and
    // counting the survivors gives the new length directly.
    kept_cnt_s = {CW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count_r) &&
          sqn_kept(mem_r[rd_ptr_r + AW'(i)][UOP_SQN_HI:UOP_SQN_LO], flush_sqn_s)) begin
        kept_cnt_s = kept_cnt_s + {{(CW-1){1'b0}}, 1'b1};
      end else begin
        kept_cnt_s = kept_cnt_s;
      end
    end

    if (flush_s) begin
      enq_idx_s    = rd_ptr_r + kept_cnt_s[AW-1:0];
      next_count_s = kept_cnt_s + {{(CW-1){1'b0}}, enq_s};
      next_rd_s    = rd_ptr_r;
      next_wr_s    = rd_ptr_r + next_count_s[AW-1:0];
    end else begin
      enq_idx_s    = wr_ptr_r;
      next_count_s = count_r + {{(CW-1){1'b0}}, enq_s} - {{(CW-1){1'b0}}, issue_s};
      next_rd_s    = rd_ptr_r + {{(AW-1){1'b0}}, issue_s};
      next_wr_s    = wr_ptr_r + {{(AW-1){1'b0}}, enq_s};
    end
  end

  // Queue control state and the issue valid bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r      <= {AW{1'b0}};
      wr_ptr_r      <= {AW{1'b0}};
      count_r       <= {CW{1'b0}};
      issued_last_r <= 1'b0;
      out_valid_r   <= 1'b0;
    end else begin
      rd_ptr_r      <= next_rd_s;
      wr_ptr_r      <= next_wr_s;
      count_r       <= next_count_s;
      issued_last_r <= issue_s;
      // Valid only on the cycle after an issue; this also clears an
      // outstanding uop that a flush kills, since no issue happens then.
      out_valid_r   <= issue_s;
    end
  end

  // Entry payload storage; contents are don't-care outside the live window.
  always_ff @(posedge clk) begin
    if (enq_s) begin
      mem_r[enq_idx_s] <= IN_uop;
    end else begin
      mem_r[enq_idx_s] <= mem_r[enq_idx_s];
    end
  end

  // Issued uop payload, captured from the head entry.
  always_ff @(posedge clk) begin
    if (issue_s) begin
      out_payload_r <= mem_r[rd_ptr_r][UOP_W-1:1];
    end else begin
      out_payload_r <= out_payload_r;
    end
  end

endmodule

// File: tb/tb_div_issue_queue.sv
// Self-checking bench for div_issue_queue: a queue-based model checked every
// cycle on the falling edge, plus directed scenarios with literal expectations.
module tb_div_issue_queue;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [51:0]  IN_branch;
  logic [170:0] IN_uop;
  logic         IN_divBusy;
  logic         OUT_full;
  logic         OUT_en;
  logic [170:0] OUT_uop;
  logic [7:0]   fire_count;

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  logic [170:0] mq[$];
  bit           m_issued_last;
  logic [170:0] m_out;
  int           m_drops;
  int           issued_log[$];

  always #5 clk = ~clk;

  div_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .IN_branch(IN_branch), .IN_uop(IN_uop),
    .IN_divBusy(IN_divBusy), .OUT_full(OUT_full), .OUT_en(OUT_en), .OUT_uop(OUT_uop)
  );

  div_issue_queue_chk chk (
    .clk(clk), .rst(rst), .uop_valid(IN_uop[0]), .uop_sqn(IN_uop[25:20]),
    .flush_valid(IN_branch[51]), .flush_sqn(IN_branch[18:13]), .full(OUT_full),
    .fire_count(fire_count)
  );

  task automatic chk_val(input string name, input logic [170:0] act, input logic [170:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_log(input string name, input int e[$]);
    bit ok;
    ok = (issued_log.size() == e.size());
    for (int i = 0; i < e.size() && ok; i++) ok = (issued_log[i] == e[i]);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: issued %p, expected %p", name, issued_log, e);
    end
    issued_log.delete();
  endtask

  // Flush survives iff wrapped (s - f) is zero or in the negative half.
  function automatic bit m_kept(input int s, input int f);
    int d;
    d = (s - f + 64) % 64;
    return (d == 0) || (d >= 32);
  endfunction

  // Every cycle: compare outputs to the model, then advance the model with the
  // inputs that the next rising edge will sample.
  initial begin
    bit           flush, in_killed, full, issue;
    int           fs;
    logic [170:0] tmp[$];
    m_issued_last = 1'b0;
    m_out = '0;
    m_drops = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mq.delete();
        m_issued_last = 1'b0;
        m_out = '0;
        m_drops = 0;
      end
      chk_val("en", OUT_en, m_out[0]);
      chk_val("full", OUT_full, (mq.size() == DEPTH));
      if (m_out[0]) begin
        chk_val("uop", OUT_uop, m_out);
      end
      if (OUT_en) issued_log.push_back(int'(OUT_uop[25:20]));
      if (!rst) begin
        flush = IN_branch[51];
        fs = int'(IN_branch[18:13]);
        in_killed = flush && !m_kept(int'(IN_uop[25:20]), fs);
        full = (mq.size() == DEPTH);
        issue = (mq.size() != 0) && !IN_divBusy && !m_issued_last && !flush;
        if (IN_uop[0] && full && !in_killed) m_drops++;
        if (issue) begin
          m_out = mq.pop_front();
          m_out[0] = 1'b1;
        end else begin
          m_out[0] = 1'b0;
        end
        if (flush) begin
          tmp.delete();
          foreach (mq[i]) if (m_kept(int'(mq[i][25:20]), fs)) tmp.push_back(mq[i]);
          mq = tmp;
        end
        if (IN_uop[0] && !full && !in_killed) mq.push_back(IN_uop);
        m_issued_last = issue;
      end
    end
  end

  function automatic logic [170:0] mk(input int sqn);
    logic [170:0] u;
    for (int i = 0; i < 171; i++) u[i] = 1'($urandom_range(0, 1));
    u[25:20] = 6'(sqn);
    u[42:37] = 6'($urandom_range(0, 3));
    u[0] = 1'b1;
    return u;
  endfunction

  function automatic logic [51:0] fl(input int sqn);
    logic [51:0] b;
    b = '0;
    b[51] = 1'b1;
    b[18:13] = 6'(sqn);
    return b;
  endfunction

  task automatic step(input logic [170:0] u, input logic [51:0] b);
    IN_uop = u;
    IN_branch = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step('0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    IN_uop = '0;
    IN_branch = '0;
    IN_divBusy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_val("rst_en", OUT_en, 1'b0);
    chk_val("rst_full", OUT_full, 1'b0);
    chk_val("rst_count", dut.count_r, 3'd0);
    rst = 1'b0;
    issued_log.delete();

    // Back-to-back enqueues, issues two cycles apart.
    step(mk(1), '0);  chk_val("s1_en0", OUT_en, 1'b0);
    step(mk(2), '0);  chk_val("s1_en1", OUT_en, 1'b1); chk_val("s1_sqn1", OUT_uop[25:20], 6'd1);
    step(mk(3), '0);  chk_val("s1_gap1", OUT_en, 1'b0);
    step('0, '0);     chk_val("s1_en2", OUT_en, 1'b1); chk_val("s1_sqn2", OUT_uop[25:20], 6'd2);
    step('0, '0);     chk_val("s1_gap2", OUT_en, 1'b0);
    step('0, '0);     chk_val("s1_en3", OUT_en, 1'b1); chk_val("s1_sqn3", OUT_uop[25:20], 6'd3);
    idle(3);
    check_log("s1_order", '{1, 2, 3});

    // Busy divider, overflow.
    IN_divBusy = 1'b1;
    for (int i = 0; i < 4; i++) step(mk(40 + i), '0);
    chk_val("s2_full", OUT_full, 1'b1);
    step(mk(44), '0);
    chk_val("s2_full_after", OUT_full, 1'b1);
    chk_val("s2_assert", fire_count, 8'd1);
    check_log("s2_noissue", '{});
    IN_divBusy = 1'b0;
    idle(12);
    check_log("s2_drain", '{40, 41, 42, 43});

    // Flush truncates the tail.
    IN_divBusy = 1'b1;
    for (int i = 4; i < 8; i++) step(mk(i), '0);
    step('0, fl(5));
    chk_val("s3_count", dut.count_r, 3'd2);
    IN_divBusy = 1'b0;
    idle(8);
    check_log("s3_drain", '{4, 5});

    // Flush together with an enqueue.
    IN_divBusy = 1'b1;
    step(mk(11), fl(10));
    chk_val("s4_killed", dut.count_r, 3'd0);
    step(mk(10), fl(10));
    chk_val("s4_kept", dut.count_r, 3'd1);
    IN_divBusy = 1'b0;
    idle(4);
    check_log("s4_drain", '{10});

    // Sequence-number wrap.
    IN_divBusy = 1'b1;
    step(mk(62), '0); step(mk(63), '0); step(mk(0), '0); step(mk(1), '0);
    step('0, fl(63));
    chk_val("s5_count", dut.count_r, 3'd2);
    IN_divBusy = 1'b0;
    idle(8);
    check_log("s5_drain", '{62, 63});
    chk_val("drops", fire_count, 8'(m_drops));

    // Asynchronous reset while full with an issue pending.
    IN_divBusy = 1'b1;
    for (int i = 0; i < 4; i++) step(mk(50 + i), '0);
    chk_val("s6_full_pre", OUT_full, 1'b1);
    IN_uop = '0;
    IN_divBusy = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_val("s6_en_rst", OUT_en, 1'b0);
    chk_val("s6_full_rst", OUT_full, 1'b0);
    chk_val("s6_count_rst", dut.count_r, 3'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    issued_log.delete();
    idle(6);
    chk_val("s6_count_post", dut.count_r, 3'd0);
    chk_val("s6_full_post", OUT_full, 1'b0);
    check_log("s6_noissue", '{});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
